// File: rtl/pulse_period_meter.sv
// Measures the spacing in clock cycles between rising edges of a pulse stream, checks it
// against EXPECTED +/- TOL, tracks lock over LOCK_N good periods and flags a sticky timeout.
module pulse_period_meter #(
    parameter int unsigned WIDTH    = 24,
    parameter int unsigned EXPECTED = 5000000,
    parameter int unsigned TOL      = 1000,
    parameter int unsigned TIMEOUT  = 10000000,
    parameter int unsigned LOCK_N   = 4
) (
    input  logic             Origin_Clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             pulse_in,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             in_range,
    output logic             locked,
    output logic             timeout
);

    localparam int unsigned LockW = $clog2(LOCK_N + 1);
    localparam logic [WIDTH-1:0] TimeoutCnt = WIDTH'(TIMEOUT);
    localparam logic [LockW-1:0] LockMax    = LockW'(LOCK_N);
    localparam logic [WIDTH-1:0] CountOne   = WIDTH'(1);

    typedef enum logic {StIdle, StMeasure} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [LockW-1:0] lock_cnt_q, lock_cnt_d;
    logic             pulse_q;
    logic             valid_q, valid_d;
    logic             in_range_q, in_range_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;

    logic             pulse_edge;
    logic [31:0]      count_ext;
    logic [31:0]      diff;
    logic             in_range_now;

    assign pulse_edge = pulse_in & ~pulse_q;

    // Difference is taken in the larger-minus-smaller order so it can never wrap.
    assign count_ext    = 32'(count_q);
    assign diff         = (count_ext >= EXPECTED) ? (count_ext - EXPECTED) : (EXPECTED - count_ext);
    assign in_range_now = (diff <= TOL);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        period_d   = period_q;
        valid_d    = 1'b0;
        in_range_d = in_range_q;
        lock_cnt_d = lock_cnt_q;
        locked_d   = locked_q;
        timeout_d  = timeout_q;

        if (clr) begin
            state_d    = StIdle;
            count_d    = '0;
            period_d   = '0;
            in_range_d = 1'b0;
            lock_cnt_d = '0;
            locked_d   = 1'b0;
            timeout_d  = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    count_d = '0;
                    if (pulse_edge) begin
                        state_d   = StMeasure;
                        count_d   = CountOne;
                        timeout_d = 1'b0;
                    end
                end
                StMeasure: begin
                    // An edge coinciding with count==TIMEOUT still reports a period.
                    if (pulse_edge) begin
                        period_d   = count_q;
                        valid_d    = 1'b1;
                        count_d    = CountOne;
                        in_range_d = in_range_now;
                        if (in_range_now) begin
                            lock_cnt_d = (lock_cnt_q == LockMax) ? LockMax : lock_cnt_q + 1'b1;
                        end else begin
                            lock_cnt_d = '0;
                        end
                        locked_d = (lock_cnt_d == LockMax);
                    end else if (count_q < TimeoutCnt) begin
                        count_d = count_q + 1'b1;
                    end else begin
                        state_d    = StIdle;
                        count_d    = '0;
                        timeout_d  = 1'b1;
                        locked_d   = 1'b0;
                        lock_cnt_d = '0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge Origin_Clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            count_q    <= '0;
            period_q   <= '0;
            pulse_q    <= 1'b0;
            valid_q    <= 1'b0;
            in_range_q <= 1'b0;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            period_q   <= period_d;
            pulse_q    <= clr ? 1'b0 : pulse_in;
            valid_q    <= valid_d;
            in_range_q <= in_range_d;
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
            timeout_q  <= timeout_d;
        end
    end

    assign period       = period_q;
    assign period_valid = valid_q;
    assign in_range     = in_range_q;
    assign locked       = locked_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Bench for pulse_period_meter: directed scenarios plus random gaps, every cycle compared
// against a timestamp-based reference model.
module tb_pulse_period_meter;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned EXPECTED = 50;
    localparam int unsigned TOL      = 2;
    localparam int unsigned TIMEOUT  = 100;
    localparam int unsigned LOCK_N   = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             clr = 1'b0;
    logic             pulse_in = 1'b0;
    logic [WIDTH-1:0] period;
    logic             period_valid;
    logic             in_range;
    logic             locked;
    logic             timeout;

    int total = 0;
    int bad   = 0;

    // Reference model: remembers the cycle of the last edge rather than a running counter.
    int               cyc = 0;
    int               last_t = 0;
    bit               active = 0;
    bit               prev = 0;
    int               m_lock = 0;
    logic [WIDTH-1:0] m_period = '0;
    logic             m_valid = 0, m_inr = 0, m_locked = 0, m_to = 0;

    pulse_period_meter #(
        .WIDTH   (WIDTH),
        .EXPECTED(EXPECTED),
        .TOL     (TOL),
        .TIMEOUT (TIMEOUT),
        .LOCK_N  (LOCK_N)
    ) dut (
        .Origin_Clock(clk),
        .reset       (reset),
        .clr         (clr),
        .pulse_in    (pulse_in),
        .period      (period),
        .period_valid(period_valid),
        .in_range    (in_range),
        .locked      (locked),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        active   = 0;
        prev     = 0;
        m_lock   = 0;
        m_period = '0;
        m_valid  = 0;
        m_inr    = 0;
        m_locked = 0;
        m_to     = 0;
    endtask

    task automatic model_tick(input bit p, input bit c);
        bit e;
        int gap;
        cyc++;
        m_valid = 0;
        if (c) begin
            model_clear();
            return;
        end
        e = p && !prev;
        prev = p;
        if (e) begin
            if (active) begin
                gap      = cyc - last_t;
                m_period = WIDTH'(gap);
                m_valid  = 1;
                m_inr    = ((gap > int'(EXPECTED)) ? gap - int'(EXPECTED) : int'(EXPECTED) - gap)
                           <= int'(TOL);
                m_lock   = m_inr ? ((m_lock + 1 > int'(LOCK_N)) ? int'(LOCK_N) : m_lock + 1) : 0;
                m_locked = (m_lock == int'(LOCK_N));
            end else begin
                active = 1;
                m_to   = 0;
            end
            last_t = cyc;
        end else if (active && (cyc - last_t == int'(TIMEOUT))) begin
            active   = 0;
            m_to     = 1;
            m_locked = 0;
            m_lock   = 0;
        end
    endtask

    task automatic check_all(input string tag);
        total++;
        assert (period === m_period) else begin
            bad++;
            $error("FAIL %s period @%0d: observed=%0d expected=%0d", tag, cyc, period, m_period);
        end
        total++;
        assert (period_valid === m_valid) else begin
            bad++;
            $error("FAIL %s period_valid @%0d: observed=%b expected=%b", tag, cyc, period_valid,
                   m_valid);
        end
        total++;
        assert (in_range === m_inr) else begin
            bad++;
            $error("FAIL %s in_range @%0d: observed=%b expected=%b", tag, cyc, in_range, m_inr);
        end
        total++;
        assert (locked === m_locked) else begin
            bad++;
            $error("FAIL %s locked @%0d: observed=%b expected=%b", tag, cyc, locked, m_locked);
        end
        total++;
        assert (timeout === m_to) else begin
            bad++;
            $error("FAIL %s timeout @%0d: observed=%b expected=%b", tag, cyc, timeout, m_to);
        end
    endtask

    // Entered and left at a falling edge.
    task automatic step(input bit p, input bit c, input string tag);
        pulse_in = p;
        clr      = c;
        @(posedge clk);
        model_tick(p, c);
        #1 check_all(tag);
        @(negedge clk);
    endtask

    task automatic pulse_gap(input int gap, input int width, input string tag);
        for (int i = 0; i < gap; i++) step(i < width, 1'b0, tag);
    endtask

    task automatic do_reset(input int n, input bit p_at_release);
        reset = 1'b0;
        model_clear();
        #1 check_all("reset_async");
        repeat (n) @(posedge clk);
        #1 check_all("reset_hold");
        @(negedge clk);
        pulse_in = p_at_release;
        reset    = 1'b1;
    endtask

    initial begin
        int gap;
        @(negedge clk);
        do_reset(2, 1'b0);

        // Steady 50-cycle one-cycle pulses until locked
        repeat (6) pulse_gap(50, 1, "steady50");
        // One 53 gap breaks lock, four 49 gaps restore it
        pulse_gap(53, 1, "gap53");
        repeat (5) pulse_gap(49, 1, "gap49");
        step(1'b1, 1'b0, "gap49_end");
        step(1'b0, 1'b0, "gap49_end");

        // Long silence -> timeout, then recovery
        pulse_gap(150, 1, "silence");
        repeat (3) pulse_gap(50, 1, "recover");

        // Wide pulses, and pulse high at reset release
        repeat (3) pulse_gap(50, 10, "wide");
        do_reset(1, 1'b1);
        repeat (4) pulse_gap(50, 10, "high_at_release");

        // TIMEOUT boundary: 100 reports, 101 times out
        repeat (3) pulse_gap(100, 1, "edge100");
        repeat (3) pulse_gap(101, 1, "edge101");

        // Reset mid-count, then clr mid-count (clr wins over a high pulse_in)
        repeat (3) pulse_gap(50, 1, "pre_reset");
        pulse_gap(20, 1, "mid_count");
        do_reset(3, 1'b0);
        repeat (3) pulse_gap(50, 1, "post_reset");
        pulse_gap(20, 1, "mid_count2");
        step(1'b1, 1'b1, "clr");
        repeat (3) pulse_gap(50, 1, "post_clr");

        // Random gaps around nominal and around the timeout
        for (int k = 0; k < 40; k++) begin
            gap = ($urandom_range(0, 4) == 0) ? int'($urandom_range(95, 105))
                                              : int'($urandom_range(46, 54));
            pulse_gap(gap, int'($urandom_range(1, 8)), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
